// File: rtl/cpu_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// cpu_mem_arbiter_if
//
// Purpose: bundles the requester-side handshakes (instruction fetch and
// load/store) and the memory-side bus of cpu_mem_arbiter.
//
// Handshake semantics (shared by both requesters):
//   A requester raises *_req with stable operands and keeps them until it sees
//   *_gnt, a one-cycle pulse in the first cycle of its memory access. It drops
//   *_req in the cycle after *_gnt unless it wants another access. *_valid is a
//   one-cycle pulse that marks completion; *_rdata holds the last read word
//   until the next read by the same requester completes.
//
// Modports:
//   slave  - arbiter view (takes requests and mem_rdata, drives grants/bus)
//   master - environment view (CPU pipeline plus memory array)
// -----------------------------------------------------------------------------
interface cpu_mem_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   // instruction fetch
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_valid;
   logic [DATA_W-1:0] if_rdata;
   // load/store
   logic              ls_req;
   logic              ls_we;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic              ls_gnt;
   logic              ls_valid;
   logic [DATA_W-1:0] ls_rdata;
   // memory array
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   // status
   logic              busy;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_valid, if_rdata,
      input  ls_req, ls_we, ls_addr, ls_wdata,
      output ls_gnt, ls_valid, ls_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output busy
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_valid, if_rdata,
      output ls_req, ls_we, ls_addr, ls_wdata,
      input  ls_gnt, ls_valid, ls_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  busy
   );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_mem_arbiter
//
// Purpose: sequences the CPU's single-port unified memory between the
// instruction-fetch unit (IF) and the load/store unit (LS). One access at a
// time: IDLE -> ACCESS (WAIT_CYCLES cycles, mem_en high) -> RESP (one cycle,
// owner's valid pulse) -> IDLE. Requests are only sampled in IDLE, so a
// request arriving during ACCESS/RESP simply waits while it is held.
//
// Parameters:
//   ADDR_W      - address width of both requesters and memory
//   DATA_W      - data word width
//   WAIT_CYCLES - cycles mem_en is held per access (>= 1)
//
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous active-high reset; abandons any access in flight
//   bus       - cpu_mem_arbiter_if.slave: IF/LS handshakes, memory bus, busy
//   state_dbg - current FSM state (IDLE=0, ACCESS=1, RESP=2)
//
// Build option:
//   CPU_ARB_FAIRNESS_EN - when defined, IF wins a tie after LS has been
//   granted three times in a row while IF was waiting. When undefined, LS
//   always wins a tie and IF can starve.
// -----------------------------------------------------------------------------
module cpu_mem_arbiter #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   cpu_mem_arbiter_if.slave       bus,
   output logic [1:0]             state_dbg
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   // The wait counter only ever holds 0 .. WAIT_CYCLES-1.
   localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);

   logic [1:0]        state;
   logic              owner_ls;   // 1 = current access belongs to LS
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [CW-1:0]     wait_cnt;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] ls_rdata_q;

   logic any_req;
   logic pick_ls;
   logic in_access;
   logic in_resp;
   logic first_access;

   assign any_req = bus.if_req | bus.ls_req;

`ifdef CPU_ARB_FAIRNESS_EN
   // Consecutive LS grants made while IF was also asking, saturating at 3.
   logic [1:0] ls_streak;
   logic       if_turn;

   assign if_turn = (ls_streak == 2'd3) && bus.if_req && bus.ls_req;
   assign pick_ls = bus.ls_req && !if_turn;

   // Updated at the same edge that selects the winner, i.e. once per grant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ls_streak <= 2'd0;
      end else if (state == IDLE && any_req) begin
         if (pick_ls && bus.if_req) begin
            if (ls_streak != 2'd3) ls_streak <= ls_streak + 2'd1;
         end else begin
            ls_streak <= 2'd0;
         end
      end
   end
`else
   assign pick_ls = bus.ls_req;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         owner_ls   <= 1'b0;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         wait_cnt   <= '0;
         if_rdata_q <= '0;
         ls_rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner_ls  <= pick_ls;
                  lat_we    <= pick_ls & bus.ls_we;
                  lat_addr  <= pick_ls ? bus.ls_addr : bus.if_addr;
                  lat_wdata <= pick_ls ? bus.ls_wdata : '0;
                  wait_cnt  <= CNT_INIT;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               if (wait_cnt == '0) begin
                  // mem_rdata is valid in the last access cycle; stores leave
                  // both read registers untouched.
                  if (!lat_we) begin
                     if (owner_ls) ls_rdata_q <= bus.mem_rdata;
                     else          if_rdata_q <= bus.mem_rdata;
                  end
                  state <= RESP;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign in_access = (state == ACCESS);
   assign in_resp   = (state == RESP);
   // The counter is loaded with CNT_INIT and only counts down, so it equals
   // CNT_INIT in exactly the first ACCESS cycle.
   assign first_access = in_access && (wait_cnt == CNT_INIT);

   assign bus.mem_en    = in_access;
   assign bus.mem_we    = in_access & lat_we;
   assign bus.mem_addr  = lat_addr;
   assign bus.mem_wdata = lat_wdata;

   assign bus.if_gnt   = first_access & ~owner_ls;
   assign bus.ls_gnt   = first_access &  owner_ls;
   assign bus.if_valid = in_resp & ~owner_ls;
   assign bus.ls_valid = in_resp &  owner_ls;
   assign bus.if_rdata = if_rdata_q;
   assign bus.ls_rdata = ls_rdata_q;
   assign bus.busy     = in_access | in_resp;

   assign state_dbg = state;

endmodule
